// File: rtl/ssf_io_pkg.sv
// Shared constants and one-hot strobe helpers for the SSF I/O controller.
// Helper functions take a fixed MAXPORTS-wide vector; callers zero-extend narrower strobes.
package ssf_io_pkg;

    localparam int NUBITS_D = 32;
    localparam int NPORTS_D = 2;
    localparam int MAXPORTS = 32;
    localparam int IDXW     = $clog2(MAXPORTS);

    function automatic logic is_onehot(input logic [MAXPORTS-1:0] v);
        return (v != '0) && ((v & (v - MAXPORTS'(1))) == '0);
    endfunction

    // Index of the lowest set bit; meaningful only when is_onehot() is true.
    function automatic logic [IDXW-1:0] onehot_idx(input logic [MAXPORTS-1:0] v);
        logic [IDXW-1:0] idx;
        idx = '0;
        for (int i = MAXPORTS - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDXW'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ssf_io_fifo.sv
// Per-port sample FIFO with a combinational head output, so the processor sees data with zero latency.
// A push into an empty FIFO becomes visible only on the following cycle.
module ssf_io_fifo #(
    parameter int NUBITS = 32,
    parameter int FDEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [NUBITS-1:0] din,
    input  logic              pop,
    output logic [NUBITS-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(FDEPTH);

    logic [NUBITS-1:0] mem [FDEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW:0]       count_reg;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_reg == (AW+1)'(FDEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr_reg];

    // Storage is deliberately not reset; only the pointers and the count are.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointers wrap naturally because FDEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/ssf_io_ctrl.sv
// Port scheduler between external sample streams and the SSF processor I/O bus.
// Protocol faults never stall the processor; they are absorbed and reported through sticky flags.
module ssf_io_ctrl
    import ssf_io_pkg::*;
#(
    parameter int NUBITS = NUBITS_D,
    parameter int NPORTS = NPORTS_D,
    parameter int FDEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NPORTS*NUBITS-1:0] s_data,
    input  logic [NPORTS-1:0]        s_valid,
    output logic [NPORTS-1:0]        s_ready,
    input  logic [NPORTS-1:0]        proc_req_in,
    output logic [NUBITS-1:0]        proc_din,
    input  logic [NUBITS-1:0]        proc_dout,
    input  logic [NPORTS-1:0]        proc_out_en,
    output logic [NPORTS*NUBITS-1:0] m_data,
    output logic [NPORTS-1:0]        m_valid,
    input  logic [NPORTS-1:0]        m_ready,
    output logic [NPORTS-1:0]        err_underflow,
    output logic [NPORTS-1:0]        err_overflow,
    output logic                     err_proto,
    input  logic                     err_clr
);

    logic [MAXPORTS-1:0] req_ext;
    logic [MAXPORTS-1:0] out_ext;
    logic                req_onehot;
    logic                out_onehot;
    logic [IDXW-1:0]     req_idx;
    logic [IDXW-1:0]     out_idx;
    logic                proto_event;

    logic [NUBITS-1:0]   head [NPORTS];
    logic [NPORTS-1:0]   fifo_empty;
    logic [NPORTS-1:0]   rd_sel;

    always_comb begin
        req_ext = '0;
        out_ext = '0;
        req_ext[NPORTS-1:0] = proc_req_in;
        out_ext[NPORTS-1:0] = proc_out_en;
    end

    assign req_onehot  = is_onehot(req_ext);
    assign out_onehot  = is_onehot(out_ext);
    assign req_idx     = onehot_idx(req_ext);
    assign out_idx     = onehot_idx(out_ext);
    // All-zero strobes are idle; only multi-hot patterns count as a protocol fault.
    assign proto_event = ((proc_req_in != '0) && !req_onehot) ||
                         ((proc_out_en != '0) && !out_onehot);

    always_comb begin
        proc_din = '0;
        for (int k = 0; k < NPORTS; k++) begin
            if (rd_sel[k] && !fifo_empty[k]) begin
                proc_din = head[k];
            end
        end
    end

    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
        logic              full;
        logic              capture;
        logic              under_event;
        logic              over_event;
        logic [NUBITS-1:0] m_data_reg;
        logic              m_valid_reg;
        logic              under_reg;
        logic              over_reg;

        assign rd_sel[gi]   = req_onehot && (req_idx == IDXW'(gi));
        assign capture      = out_onehot && (out_idx == IDXW'(gi));
        assign under_event  = rd_sel[gi] && fifo_empty[gi];
        assign over_event   = capture && m_valid_reg && !m_ready[gi];
        assign s_ready[gi]  = !full;

        ssf_io_fifo #(
            .NUBITS (NUBITS),
            .FDEPTH (FDEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (s_valid[gi]),
            .din   (s_data[gi*NUBITS +: NUBITS]),
            .pop   (rd_sel[gi]),
            .dout  (head[gi]),
            .full  (full),
            .empty (fifo_empty[gi])
        );

        // A capture wins over consumption, so valid stays high when both happen together.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                m_data_reg  <= '0;
                m_valid_reg <= 1'b0;
            end else if (capture) begin
                m_data_reg  <= proc_dout;
                m_valid_reg <= 1'b1;
            end else if (m_valid_reg && m_ready[gi]) begin
                m_valid_reg <= 1'b0;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                under_reg <= 1'b0;
                over_reg  <= 1'b0;
            end else begin
                under_reg <= under_event || (under_reg && !err_clr);
                over_reg  <= over_event || (over_reg && !err_clr);
            end
        end

        assign m_data[gi*NUBITS +: NUBITS] = m_data_reg;
        assign m_valid[gi]                 = m_valid_reg;
        assign err_underflow[gi]           = under_reg;
        assign err_overflow[gi]            = over_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_proto <= 1'b0;
        end else begin
            err_proto <= proto_event || (err_proto && !err_clr);
        end
    end

endmodule

// File: tb/tb_ssf_io_ctrl.sv
// Directed self-checking bench for ssf_io_ctrl: one task per scenario, hand-computed expectations.
module tb_ssf_io_ctrl;

    localparam int NUBITS = 32;
    localparam int NPORTS = 2;
    localparam int FDEPTH = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NPORTS*NUBITS-1:0] s_data;
    logic [NPORTS-1:0]        s_valid;
    logic [NPORTS-1:0]        s_ready;
    logic [NPORTS-1:0]        proc_req_in;
    logic [NUBITS-1:0]        proc_din;
    logic [NUBITS-1:0]        proc_dout;
    logic [NPORTS-1:0]        proc_out_en;
    logic [NPORTS*NUBITS-1:0] m_data;
    logic [NPORTS-1:0]        m_valid;
    logic [NPORTS-1:0]        m_ready;
    logic [NPORTS-1:0]        err_underflow;
    logic [NPORTS-1:0]        err_overflow;
    logic                     err_proto;
    logic                     err_clr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ssf_io_ctrl #(.NUBITS(NUBITS), .NPORTS(NPORTS), .FDEPTH(FDEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .proc_req_in   (proc_req_in),
        .proc_din      (proc_din),
        .proc_dout     (proc_dout),
        .proc_out_en   (proc_out_en),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .err_underflow (err_underflow),
        .err_overflow  (err_overflow),
        .err_proto     (err_proto),
        .err_clr       (err_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s_valid     = '0;
        proc_req_in = '0;
        proc_out_en = '0;
        err_clr     = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        s_data = '0; proc_dout = '0; m_ready = '0;
        rst = 1'b1;
        #12;
        n_cmp++;
        if (s_ready !== 2'b11 || m_valid !== 2'b00 || m_data !== '0 || proc_din !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: s_ready=%b m_valid=%b m_data=%h proc_din=%h required 11 00 0 0",
                     s_ready, m_valid, m_data, proc_din);
        end
        n_cmp++;
        if (err_underflow !== 2'b00 || err_overflow !== 2'b00 || err_proto !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags: uf=%b of=%b proto=%b required 00 00 0",
                     err_underflow, err_overflow, err_proto);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        $display("reset: done");
    endtask

    task automatic test_basic_read();
        logic [NPORTS-1:0] reqs [4];
        logic [NUBITS-1:0] exp  [4];
        reqs = '{2'b01, 2'b10, 2'b01, 2'b01};
        exp  = '{32'd3, 32'd100, 32'd5, 32'd7};
        s_valid = 2'b01; s_data = {32'd0, 32'd3}; tick();
        s_data = {32'd0, 32'd5}; tick();
        s_valid = 2'b11; s_data = {32'd100, 32'd7}; tick();
        s_valid = 2'b00;
        for (int i = 0; i < 4; i++) begin
            proc_req_in = reqs[i];
            #1;
            n_cmp++;
            if (proc_din !== exp[i]) begin
                n_bad++;
                $display("FAIL basic_read[%0d]: proc_din=%0d required %0d", i, proc_din, exp[i]);
            end
            $display("basic_read: req=%b proc_din=%0d", reqs[i], proc_din);
            tick();
        end
        proc_req_in = '0;
        #1;
        n_cmp++;
        if (err_underflow !== 2'b00 || err_proto !== 1'b0 || s_ready !== 2'b11) begin
            n_bad++;
            $display("FAIL basic_after: uf=%b proto=%b s_ready=%b required 00 0 11",
                     err_underflow, err_proto, s_ready);
        end
    endtask

    task automatic test_full();
        for (int i = 1; i <= 4; i++) begin
            s_valid = 2'b10; s_data = {32'(i), 32'd0}; tick();
        end
        n_cmp++;
        if (s_ready[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL full_ready: s_ready[1]=%b required 0", s_ready[1]);
        end
        s_data = {32'd5, 32'd0}; tick();
        s_valid = 2'b00;
        for (int i = 1; i <= 4; i++) begin
            proc_req_in = 2'b10;
            #1;
            n_cmp++;
            if (proc_din !== 32'(i)) begin
                n_bad++;
                $display("FAIL full_read[%0d]: proc_din=%0d required %0d", i, proc_din, i);
            end
            $display("full_read: proc_din=%0d", proc_din);
            tick();
            if (i == 1) begin
                n_cmp++;
                if (s_ready[1] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL full_reopen: s_ready[1]=%b required 1", s_ready[1]);
                end
            end
        end
        proc_req_in = '0;
        #1;
        n_cmp++;
        if (err_underflow !== 2'b00) begin
            n_bad++;
            $display("FAIL full_no5th: err_underflow=%b required 00", err_underflow);
        end
    endtask

    task automatic test_underflow();
        proc_req_in = 2'b01; s_valid = 2'b01; s_data = {32'd0, 32'd11};
        #1;
        n_cmp++;
        if (proc_din !== '0) begin
            n_bad++;
            $display("FAIL underflow_din: proc_din=%0d required 0", proc_din);
        end
        tick();
        idle();
        #1;
        n_cmp++;
        if (err_underflow !== 2'b01) begin
            n_bad++;
            $display("FAIL underflow_flag: err_underflow=%b required 01", err_underflow);
        end
        proc_req_in = 2'b01;
        #1;
        n_cmp++;
        if (proc_din !== 32'd11) begin
            n_bad++;
            $display("FAIL underflow_next: proc_din=%0d required 11", proc_din);
        end
        $display("underflow: flag=%b next read=%0d", err_underflow, proc_din);
        tick();
        proc_req_in = '0; err_clr = 1'b1; tick(); err_clr = 1'b0;
        n_cmp++;
        if (err_underflow !== 2'b00) begin
            n_bad++;
            $display("FAIL underflow_clr: err_underflow=%b required 00", err_underflow);
        end
    endtask

    task automatic test_output();
        proc_out_en = 2'b10; proc_dout = -32'sd42; m_ready = 2'b00; tick();
        n_cmp++;
        if (m_valid !== 2'b10 || m_data[63:32] !== 32'hFFFF_FFD6) begin
            n_bad++;
            $display("FAIL out_first: m_valid=%b m_data1=%h required 10 ffffffd6", m_valid, m_data[63:32]);
        end
        proc_dout = 32'd9; tick();
        n_cmp++;
        if (m_data[63:32] !== 32'd9 || m_valid[1] !== 1'b1 || err_overflow !== 2'b10) begin
            n_bad++;
            $display("FAIL out_overflow: m_data1=%0d m_valid1=%b of=%b required 9 1 10",
                     m_data[63:32], m_valid[1], err_overflow);
        end
        $display("output: overwrite m_data1=%0d of=%b", m_data[63:32], err_overflow);
        proc_out_en = '0; err_clr = 1'b1; tick(); err_clr = 1'b0;
        proc_out_en = 2'b10; proc_dout = 32'd20; m_ready = 2'b10; tick();
        n_cmp++;
        if (m_data[63:32] !== 32'd20 || m_valid[1] !== 1'b1 || err_overflow !== 2'b00) begin
            n_bad++;
            $display("FAIL out_consume_load: m_data1=%0d m_valid1=%b of=%b required 20 1 00",
                     m_data[63:32], m_valid[1], err_overflow);
        end
        proc_out_en = '0; tick();
        n_cmp++;
        if (m_valid !== 2'b00 || m_data[63:32] !== 32'd20) begin
            n_bad++;
            $display("FAIL out_drain: m_valid=%b m_data1=%0d required 00 20", m_valid, m_data[63:32]);
        end
        m_ready = '0;
        $display("output: drained m_valid=%b", m_valid);
    endtask

    task automatic test_proto();
        s_valid = 2'b11; s_data = {32'd40, 32'd30}; tick();
        s_valid = 2'b00; proc_req_in = 2'b11;
        #1;
        n_cmp++;
        if (proc_din !== '0) begin
            n_bad++;
            $display("FAIL proto_din: proc_din=%0d required 0", proc_din);
        end
        tick();
        proc_req_in = 2'b01;
        #1;
        n_cmp++;
        if (err_proto !== 1'b1 || proc_din !== 32'd30) begin
            n_bad++;
            $display("FAIL proto_flag: err_proto=%b head0=%0d required 1 30", err_proto, proc_din);
        end
        proc_req_in = '0; err_clr = 1'b1; tick();
        n_cmp++;
        if (err_proto !== 1'b0) begin
            n_bad++;
            $display("FAIL proto_clr: err_proto=%b required 0", err_proto);
        end
        proc_out_en = 2'b11; tick();
        idle();
        n_cmp++;
        if (err_proto !== 1'b1 || m_valid !== 2'b00) begin
            n_bad++;
            $display("FAIL proto_clr_race: err_proto=%b m_valid=%b required 1 00", err_proto, m_valid);
        end
        $display("proto: flag after clr+violation=%b", err_proto);
    endtask

    task automatic test_async_reset();
        s_valid = 2'b01; s_data = {32'd0, 32'd50}; tick();
        s_valid = 2'b00; proc_out_en = 2'b01; proc_dout = 32'd77; tick();
        proc_out_en = 2'b00;
        n_cmp++;
        if (m_valid[0] !== 1'b1 || err_proto !== 1'b1) begin
            n_bad++;
            $display("FAIL arst_setup: m_valid0=%b err_proto=%b required 1 1", m_valid[0], err_proto);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (s_ready !== 2'b11 || m_valid !== 2'b00 || err_proto !== 1'b0 ||
            err_underflow !== 2'b00 || err_overflow !== 2'b00 || m_data !== '0) begin
            n_bad++;
            $display("FAIL arst_immediate: s_ready=%b m_valid=%b proto=%b uf=%b of=%b m_data=%h required 11 00 0 00 00 0",
                     s_ready, m_valid, err_proto, err_underflow, err_overflow, m_data);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        proc_req_in = 2'b01;
        #1;
        n_cmp++;
        if (proc_din !== '0) begin
            n_bad++;
            $display("FAIL arst_empty_din: proc_din=%0d required 0", proc_din);
        end
        tick();
        proc_req_in = '0;
        n_cmp++;
        if (err_underflow !== 2'b01) begin
            n_bad++;
            $display("FAIL arst_underflow: err_underflow=%b required 01", err_underflow);
        end
        $display("async_reset: post-release underflow=%b", err_underflow);
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_full();
        test_underflow();
        test_output();
        test_proto();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
